// File: rtl/tcdm_bank_arbiter.sv
// Per-bank TCDM arbiter: round-robin with starvation aging, stall lock and response routing.
// Optional statistics counters are enabled by defining TCDM_ARB_STATS_EN.
module tcdm_bank_arbiter #(
  parameter int NumIn         = 8,
  parameter int ReqDataWidth  = 49,
  parameter int RespDataWidth = 32,
  parameter int RespLat       = 1,
  parameter int WriteRespOn   = 1,
  parameter int StarveThresh  = 15
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumIn-1:0]                     req_i,
  input  logic [NumIn-1:0]                     wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]   wdata_i,
  output logic [NumIn-1:0]                     gnt_o,
  output logic [NumIn-1:0]                     vld_o,
  output logic [RespDataWidth-1:0]             rdata_o,
  output logic                                 req_o,
  input  logic                                 gnt_i,
  output logic [ReqDataWidth-1:0]              wdata_o,
  input  logic [RespDataWidth-1:0]             rdata_i
`ifdef TCDM_ARB_STATS_EN
  ,
  output logic [31:0]                          conflict_cnt_o,
  output logic [31:0]                          stall_cnt_o
`endif
);

  localparam int IdxW = $clog2(NumIn);
  localparam int CntW = $clog2(StarveThresh + 1);
  localparam logic [CntW-1:0] Thresh = CntW'(StarveThresh);
  localparam logic [IdxW:0]   NumInW = (IdxW+1)'(NumIn);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [CntW-1:0] wait_cnt_q [NumIn];
  logic [CntW-1:0] wait_cnt_d [NumIn];
  logic [RespLat-1:0] pv_q;
  logic [IdxW-1:0]    pidx_q [RespLat];

  logic [IdxW-1:0] win;
  logic [IdxW:0]   cand;
  logic            starve_hit;
  logic            hs;
  logic            push_v;

  assign req_o   = |req_i;
  assign hs      = req_o & gnt_i;
  assign wdata_o = wdata_i[win];
  assign rdata_o = rdata_i;
  assign gnt_o   = hs ? (NumIn'(1) << win) : '0;
  assign vld_o   = pv_q[RespLat-1] ? (NumIn'(1) << pidx_q[RespLat-1]) : '0;
  assign push_v  = hs & (~wen_i[win] | (WriteRespOn != 0));

  // Downward loops let the last hit stand: lowest starving index, nearest rr candidate.
  always_comb begin
    win        = '0;
    cand       = '0;
    starve_hit = 1'b0;
    if (lock_q && req_i[lock_idx_q]) begin
      win = lock_idx_q;
    end else begin
      for (int i = NumIn-1; i >= 0; i--) begin
        if (req_i[i] && (wait_cnt_q[i] >= Thresh)) begin
          win        = IdxW'(i);
          starve_hit = 1'b1;
        end
      end
      if (!starve_hit) begin
        for (int k = NumIn-1; k >= 0; k--) begin
          cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
          if (cand >= NumInW) cand = cand - NumInW;
          if (req_i[cand[IdxW-1:0]]) win = cand[IdxW-1:0];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    if (hs) rr_ptr_d = (win == IdxW'(NumIn-1)) ? '0 : win + IdxW'(1);
    // A stalled request re-locks onto whatever won this cycle; anything else releases.
    lock_d     = req_o & ~gnt_i;
    lock_idx_d = lock_d ? win : lock_idx_q;
    for (int i = 0; i < NumIn; i++) begin
      if (req_i[i] && !gnt_o[i])
        wait_cnt_d[i] = (wait_cnt_q[i] >= Thresh) ? Thresh : wait_cnt_q[i] + CntW'(1);
      else
        wait_cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      pv_q       <= '0;
      for (int i = 0; i < NumIn; i++) wait_cnt_q[i] <= '0;
      for (int k = 0; k < RespLat; k++) pidx_q[k] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int i = 0; i < NumIn; i++) wait_cnt_q[i] <= wait_cnt_d[i];
      pv_q[0]    <= push_v;
      pidx_q[0]  <= win;
      for (int k = 1; k < RespLat; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pidx_q[k] <= pidx_q[k-1];
      end
    end
  end

`ifdef TCDM_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      if ($countones(req_i) >= 2) conflict_cnt_o <= conflict_cnt_o + 32'd1;
      if (req_o && !gnt_i)        stall_cnt_o    <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
